// File: rtl/window_feed.sv
// Streaming window generator: IMG_NB adjacent same-row pixels per window, at a fixed column stride.
// Latency: img/val/last registered, 1 cycle after the pixel that completes a window.
// Backpressure: none; every pix_val pixel is consumed, and idle gaps are transparent.
module window_feed #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int ROW_LEN   = 8,
  parameter int STRIDE    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IMG_WIDTH-1:0]        pix,
  input  logic                        pix_val,
  input  logic                        sor,
  output logic [IMG_WIDTH*IMG_NB-1:0] img,
  output logic                        val,
  output logic                        last
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int HW = IMG_WIDTH * (IMG_NB - 1);

  // First column that can complete a window, the column completing the row's final window,
  // and the last column of a row.
  localparam logic [CW-1:0] FIRST_COL = CW'(IMG_NB - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_NB - 1 + ((ROW_LEN - IMG_NB) / STRIDE) * STRIDE);
  localparam logic [CW-1:0] END_COL   = CW'(ROW_LEN - 1);
  localparam logic [SW-1:0] RELOAD    = SW'(STRIDE - 1);

  // The newest pixel is taken straight from the input, so only IMG_NB-1 older lanes are stored.
  logic [HW-1:0]               r_sh;
  logic [CW-1:0]               r_col;
  logic [SW-1:0]               r_scnt;
  logic [IMG_WIDTH*IMG_NB-1:0] r_img;
  logic                        r_val;
  logic                        r_last;

  logic [CW-1:0]               w_col;
  logic [CW-1:0]               w_col_nxt;
  logic [SW-1:0]               w_scnt_nxt;
  logic [IMG_WIDTH*IMG_NB-1:0] w_win;
  logic                        w_emit;
  logic                        w_last;

  // Window assembly, column tracking and the stride down-counter decision for the current pixel.
  always_comb begin
    w_col      = sor ? '0 : r_col;
    w_col_nxt  = (w_col == END_COL) ? '0 : w_col + CW'(1);
    w_win      = {pix, r_sh};
    w_emit     = 1'b0;
    w_scnt_nxt = r_scnt;
    if (w_col == FIRST_COL) begin
      // First eligible column of the row always emits and restarts the stride count.
      w_emit     = 1'b1;
      w_scnt_nxt = RELOAD;
    end else if (w_col > FIRST_COL) begin
      if (r_scnt == '0) begin
        w_emit     = 1'b1;
        w_scnt_nxt = RELOAD;
      end else begin
        w_scnt_nxt = r_scnt - SW'(1);
      end
    end
    w_last = w_emit && (w_col == LAST_COL);
  end

  // State and registered outputs; val/last are single-cycle pulses, img holds between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh   <= '0;
      r_col  <= '0;
      r_scnt <= '0;
      r_img  <= '0;
      r_val  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_val  <= 1'b0;
      r_last <= 1'b0;
      if (pix_val) begin
        r_sh   <= w_win[IMG_WIDTH*IMG_NB-1:IMG_WIDTH];
        r_col  <= w_col_nxt;
        r_scnt <= w_scnt_nxt;
        if (w_emit) begin
          r_img  <= w_win;
          r_val  <= 1'b1;
          r_last <= w_last;
        end
      end
    end
  end

  assign img  = r_img;
  assign val  = r_val;
  assign last = r_last;

endmodule

// File: tb/tb_window_feed.sv
module tb_window_feed;

  typedef struct packed {
    logic [47:0] img;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pix1 = '0, pix2 = '0;
  logic        pv1 = 1'b0, pv2 = 1'b0;
  logic        sor1 = 1'b0, sor2 = 1'b0;
  logic [47:0] img1, img2;
  logic        val1, val2, last1, last2;

  int   tests = 0;
  int   fails = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  window_feed #(.IMG_WIDTH(16), .IMG_NB(3), .ROW_LEN(8), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .pix(pix1), .pix_val(pv1), .sor(sor1),
    .img(img1), .val(val1), .last(last1)
  );

  window_feed #(.IMG_WIDTH(16), .IMG_NB(3), .ROW_LEN(8), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .pix(pix2), .pix_val(pv2), .sor(sor2),
    .img(img2), .val(val2), .last(last2)
  );

  function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic l);
    exp_t e;
    e.img  = {c, b, a};
    e.last = l;
    return e;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic px1(input logic [15:0] p, input logic s);
    pix1 = p; sor1 = s; pv1 = 1'b1;
    @(posedge clk); #1;
    pv1 = 1'b0; sor1 = 1'b0;
  endtask

  task automatic px2(input logic [15:0] p);
    pix2 = p; pv2 = 1'b1;
    @(posedge clk); #1;
    pv2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitor for the STRIDE=1 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (val1) begin
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL s1_unexpected_val: got img %h last %b, expected no window", img1, last1);
        end else begin
          e = q1.pop_front();
          tests++;
          if (img1 !== e.img || last1 !== e.last) begin
            fails++;
            $display("FAIL s1_window: got img %h last %b, expected img %h last %b",
                     img1, last1, e.img, e.last);
          end
        end
      end else if (last1) begin
        fails++;
        $display("FAIL s1_last_without_val: got last 1, expected 0");
      end
    end
  end

  // Scoreboard monitor for the STRIDE=2 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (val2) begin
        if (q2.size() == 0) begin
          fails++;
          $display("FAIL s2_unexpected_val: got img %h last %b, expected no window", img2, last2);
        end else begin
          e = q2.pop_front();
          tests++;
          if (img2 !== e.img || last2 !== e.last) begin
            fails++;
            $display("FAIL s2_window: got img %h last %b, expected img %h last %b",
                     img2, last2, e.img, e.last);
          end
        end
      end else if (last2) begin
        fails++;
        $display("FAIL s2_last_without_val: got last 1, expected 0");
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    check("reset_img", img1, 48'h0);
    check("reset_val", {47'h0, val1}, 48'h0);
    check("reset_last", {47'h0, last1}, 48'h0);
    rst = 1'b0;
    idle(2);

    // Single row, stride 1: six windows, last on (6,7,8)
    for (int i = 1; i <= 6; i++)
      q1.push_back(mk(16'(i), 16'(i + 1), 16'(i + 2), i == 6));
    for (int i = 1; i <= 8; i++) px1(16'(i), 1'b0);
    idle(3);

    // Same row with a 5-cycle gap after pixel 3: window sequence unchanged, img held
    for (int i = 1; i <= 6; i++)
      q1.push_back(mk(16'(i), 16'(i + 1), 16'(i + 2), i == 6));
    for (int i = 1; i <= 3; i++) px1(16'(i), 1'b0);
    for (int g = 0; g < 5; g++) begin
      @(posedge clk); #1;
      check("gap_val", {47'h0, val1}, 48'h0);
      check("gap_img_hold", img1, {16'd3, 16'd2, 16'd1});
    end
    for (int i = 4; i <= 8; i++) px1(16'(i), 1'b0);
    idle(3);

    // Stride 2: (1,2,3),(3,4,5),(5,6,7) last; pixel 8 absorbed
    q2.push_back(mk(16'd1, 16'd2, 16'd3, 1'b0));
    q2.push_back(mk(16'd3, 16'd4, 16'd5, 1'b0));
    q2.push_back(mk(16'd5, 16'd6, 16'd7, 1'b1));
    for (int i = 1; i <= 8; i++) px2(16'(i));
    idle(3);

    // Two rows back-to-back: never a window straddling the row boundary
    for (int r = 0; r < 2; r++)
      for (int i = 1; i <= 6; i++)
        q1.push_back(mk(16'(8 * r + i), 16'(8 * r + i + 1), 16'(8 * r + i + 2), i == 6));
    for (int i = 1; i <= 16; i++) px1(16'(i), 1'b0);
    idle(3);

    // sor mid-row discards the partial window; negative pixels pass bit-exact
    q1.push_back(mk(16'd50, 16'd51, 16'd52, 1'b0));
    q1.push_back(mk(16'hFFFF, 16'hFFFE, 16'hFFFD, 1'b0));
    px1(16'd1, 1'b0);
    px1(16'd2, 1'b0);
    px1(16'd50, 1'b1);
    px1(16'd51, 1'b0);
    px1(16'd52, 1'b0);
    idle(2);
    px1(16'hFFFF, 1'b1);
    px1(16'hFFFE, 1'b0);
    px1(16'hFFFD, 1'b0);
    idle(3);

    // Asynchronous reset mid-row clears outputs immediately
    q1.push_back(mk(16'd1, 16'd2, 16'd3, 1'b0));
    q1.push_back(mk(16'd2, 16'd3, 16'd4, 1'b0));
    px1(16'd1, 1'b1);
    px1(16'd2, 1'b0);
    px1(16'd3, 1'b0);
    px1(16'd4, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_img", img1, 48'h0);
    check("async_rst_val", {47'h0, val1}, 48'h0);
    check("async_rst_last", {47'h0, last1}, 48'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    // After release the first pixel is column 0 without sor
    q1.push_back(mk(16'd1, 16'd2, 16'd3, 1'b0));
    px1(16'd1, 1'b0);
    px1(16'd2, 1'b0);
    px1(16'd3, 1'b0);
    idle(4);

    check("s1_pending_windows", 48'(q1.size()), 48'h0);
    check("s2_pending_windows", 48'(q2.size()), 48'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window_feed.md
Name: window_feed

Overview:
- Streaming window generator that drives the img/val input of the type3 convolution MAC chain.
- Accepts one signed pixel per cycle from a row-ordered scalar stream with a valid qualifier.
- Emits IMG_NB adjacent same-row pixels as a packed vector plus val, at a programmable horizontal stride.
- Windows never straddle a row boundary; each emitted window is one complete dot-product operand set for type3.

Parameters:
IMG_WIDTH, 16, bits per pixel (signed two's complement, passed through unmodified)
IMG_NB, 3, pixels per window; must equal type3 IMG_NB; legal range 2..ROW_LEN
ROW_LEN, 8, pixels per image row; must be >= IMG_NB
STRIDE, 1, column step between successive window starts; legal range 1..ROW_LEN-IMG_NB+1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
pix  input  IMG_WIDTH  incoming pixel
pix_val  input  1  pix valid this cycle; no backpressure, every valid pixel is consumed
sor  input  1  start-of-row; qualified by pix_val, forces the current pixel to column 0
img  output  IMG_WIDTH*IMG_NB  window; lane k at img[k*IMG_WIDTH +: IMG_WIDTH], lane 0 = oldest (leftmost) pixel
val  output  1  img holds a new window this cycle (single-cycle pulse per window)
last  output  1  asserted with val on the final window of a row

Behaviour:
- Reset (async, any time, including mid-row): img=0, val=0, last=0; column counter=0; stride counter=0; shift register cleared. First valid pixel after reset release is column 0.
- Shift register: on pix_val, pixels shift toward lane 0 and pix enters lane IMG_NB-1. No shift when pix_val=0; contents hold indefinitely, so input gaps of any length are transparent.
- Column counter col: counts 0..ROW_LEN-1 on each pix_val and wraps to 0 after ROW_LEN-1. If sor=1 with pix_val=1, the pixel is column 0 regardless of col; the partially collected window is discarded. sor without pix_val is ignored.
- Emission condition, evaluated on the accepted pixel at column c:
  - c >= IMG_NB-1, and
  - (c-(IMG_NB-1)) is a multiple of STRIDE, implemented with a down-counter reloaded at the first eligible column, not with a modulo.
- Latency: img/val/last are registered and appear 1 cycle after the completing pixel is sampled. val=0 on all other cycles. img retains its last window while val=0.
- Window count per row: floor((ROW_LEN-IMG_NB)/STRIDE)+1.
- last: asserted with the highest-start-column window of the row. Trailing pixels after that window, up to ROW_LEN-1, are absorbed silently.
- Row wrap: a pixel at column 0 starts a fresh window. Lanes holding the previous row are never combined with the new row, because emission requires c >= IMG_NB-1 within the current row.
- Arithmetic: no width changes; pixels are bit-exact copies.
- Throughput: one window per cycle maximum (STRIDE=1, pix_val continuous).

Test Plan:
- IMG_NB=3, ROW_LEN=8, STRIDE=1; pix 1..8 on consecutive cycles -> 6 val pulses, windows (1,2,3),(2,3,4)…(6,7,8) in lane order 0,1,2. Each appears 1 cycle after its third pixel. last only on (6,7,8).
- Same stream with 5 idle cycles between pixels 3 and 4 -> identical window sequence. val=0 and img=(1,2,3) held through the gap.
- STRIDE=2; pix 1..8 -> windows (1,2,3),(3,4,5),(5,6,7) with last on (5,6,7). Pixel 8 produces no val.
- Two rows back-to-back, pix 1..16, STRIDE=1 -> row 2 first window is (9,10,11). No (7,8,9) or (8,9,10) is ever emitted. last on (6,7,8) and (14,15,16).
- sor with pix_val on pixel value 50 after 2 pixels of a row, then 51,52 -> next window is (50,51,52). Negative pixels -1,-2,-3 pass through bit-exact (0xFFFF,0xFFFE,0xFFFD).
- Assert rst mid-row after pixels 1..4 -> val/last/img=0 immediately (asynchronously). After release, pix 1..3 -> first window (1,2,3).
